dmem_sized: RTL and testbench
=============================

DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter r, default 7, giving the word-address bits; depth is 2^r words.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port memReq, input, 1 bit, request strobe.
REQ-006 The block SHALL have port memWrite, input, 1 bit; 1 = store, 0 = load.
REQ-007 The block SHALL have port memSize, input, 2 bits: 00 byte, 01 half, 10 word, 11 doubleword (legal only when n=64).
REQ-008 The block SHALL have port memUnsigned, input, 1 bit; 1 = zero-extend loads, 0 = sign-extend loads.
REQ-009 The block SHALL have port memClear, input, 1 bit, which starts a full-memory clear.
REQ-010 The block SHALL have port addr, input, n bits, a byte address.
REQ-011 The block SHALL have port writeData, input, n bits; store data is right-justified.
REQ-012 The block SHALL have port readData, output, n bits, the registered load result.
REQ-013 The block SHALL have port readValid, output, 1 bit, a one-cycle load-completion pulse.
REQ-014 The block SHALL have port memError, output, 1 bit, a one-cycle fault pulse.
REQ-015 The block SHALL have port busy, output, 1 bit, high while clearing.

Function
REQ-016 The block SHALL implement a two-state FSM, CLEAR and IDLE; busy = (state == CLEAR).
REQ-017 In CLEAR the block SHALL zero one word per cycle at counter index 0..2^r-1, then enter IDLE after the last word.
REQ-018 In IDLE, memClear=1 SHALL enter CLEAR with the counter at 0; memClear has priority over a same-cycle memReq, which is dropped.
REQ-019 memReq in CLEAR, and memClear in CLEAR, SHALL be ignored with no state change.
REQ-020 A request SHALL be accepted on a rising edge with memReq=1 in IDLE; back-to-back requests SHALL be accepted every cycle.
REQ-021 A legal store SHALL update only the addressed byte lanes (little-endian, lane = addr low bits) at the accepting edge; readValid SHALL stay 0.
REQ-022 A legal load SHALL drive readData and pulse readValid=1 exactly one cycle after acceptance, and readData SHALL hold until the next load or fault.
REQ-023 A load SHALL extract the addressed lanes, right-justify them, and sign- or zero-extend them to n bits per memUnsigned.
REQ-024 A load immediately following a store to the same address SHALL return the new data.
REQ-025 A fault SHALL be any of: misalignment (half addr[0]!=0, word addr[1:0]!=0, doubleword addr[2:0]!=0), memSize=11 with n=32, or an address above depth (nonzero bits above the word-address field).
REQ-026 On a fault the block SHALL leave memory unchanged and pulse memError=1 one cycle after acceptance; for loads it SHALL also pulse readValid=1 with readData=0.

Reset
REQ-027 reset SHALL asynchronously force state=CLEAR, counter=0, readData=0, readValid=0, memError=0; the clear starts on the first edge after deassertion.
REQ-028 reset asserted mid-clear or mid-request SHALL abort that operation and restart the clear from word 0.

Structure
REQ-029 A shared package dmem_pkg SHALL hold the memSize enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and the state enum (ST_CLEAR, ST_IDLE).
REQ-030 Lane extraction and extension SHALL reside in a combinational sub-module dmem_load_align.

Verification (n=32, r=7)
REQ-031 The bench SHALL cover: reset pulse -> busy=1 for 128 cycles, then a word load at 0x54 -> readData=0x00000000 with readValid one cycle later.
REQ-032 The bench SHALL cover: word store 0xDEADBEEF at 0x54, then a word load -> 0xDEADBEEF; a signed byte load at 0x57 -> 0xFFFFFFDE; an unsigned byte load at 0x57 -> 0x000000DE.
REQ-033 The bench SHALL cover: word store 0x11223344 at 0xA8, then half store 0xACAC at 0xAA, then a word load at 0xA8 -> 0xACAC3344.
REQ-034 The bench SHALL cover: word store at 0xA9, and separately a load at 0x200 -> memError pulse, memory unchanged, and the load returns readValid=1 with readData=0.
REQ-035 The bench SHALL cover: memClear with a same-cycle memReq -> request dropped, busy=1, memory zeroed after 128 cycles.
REQ-036 The bench SHALL cover: reset asserted 50 cycles into a clear -> the clear restarts from word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access-size and controller-state encodings.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Number of bytes touched by an access of the given size.
  function automatic int size_bytes(input size_e sz);
    return 1 << int'(sz);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path: pick the addressed byte lanes out of a memory word, right-justify and extend.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0]             word,
  input  logic [$clog2(n/8)-1:0]   off,
  input  logic [1:0]               size,
  input  logic                     unsgn,
  output logic [n-1:0]             data
);

  logic [n-1:0] sh;
  int           nbits;
  logic         sgn;

  always_comb begin
    sh    = word >> {off, 3'b000};
    nbits = 8 * size_bytes(size_e'(size));
    if (nbits > int'(n)) nbits = int'(n);
    sgn = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      if (i == nbits - 1) sgn = sh[i];
    end
    // Bits above the access width carry the sign bit for signed loads, zero otherwise.
    for (int i = 0; i < int'(n); i++) begin
      data[i] = (i < nbits) ? sh[i] : (sgn & ~unsgn);
    end
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed data memory with sized/extended loads, lane-masked stores,
// fault detection and a word-per-cycle clear sequencer.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned n = 32,
  parameter int unsigned r = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memReq,
  input  logic         memWrite,
  input  logic [1:0]   memSize,
  input  logic         memUnsigned,
  input  logic         memClear,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writeData,
  output logic [n-1:0] readData,
  output logic         readValid,
  output logic         memError,
  output logic         busy
);

  localparam int unsigned nb    = n / 8;
  localparam int unsigned lb    = $clog2(nb);
  localparam int unsigned depth = 1 << r;
  localparam int unsigned aw    = r + lb;

  logic [n-1:0] mem [depth];

  state_e       state, state_n;
  logic [r-1:0] cnt, cnt_n;
  logic [n-1:0] rd_n;
  logic         rv_n, err_n;

  logic [r-1:0]  widx;
  logic [lb-1:0] off;
  logic [n-1:0]  rword, load_data, wdata_sh;
  logic [nb-1:0] lane_mask;
  logic          misalign, oor, fault, accept;

  assign widx  = addr[aw-1:lb];
  assign off   = addr[lb-1:0];
  assign rword = mem[widx];
  assign busy  = (state == ST_CLEAR);

  // Fault decode and store lane selection.
  always_comb begin
    misalign = 1'b0;
    case (size_e'(memSize))
      SZ_HALF:  misalign = addr[0];
      SZ_WORD:  misalign = (addr[1:0] != 2'b00);
      SZ_DWORD: misalign = (n == 32) || (addr[2:0] != 3'b000);
      default:  misalign = 1'b0;
    endcase
    oor   = (addr >> aw) != '0;
    fault = misalign | oor;
    for (int i = 0; i < int'(nb); i++) begin
      lane_mask[i] = (i >= int'(off)) && (i < int'(off) + size_bytes(size_e'(memSize)));
    end
    wdata_sh = writeData << {off, 3'b000};
  end

  assign accept = (state == ST_IDLE) && memReq && !memClear;

  dmem_load_align #(.n(n)) u_align (
    .word  (rword),
    .off   (off),
    .size  (memSize),
    .unsgn (memUnsigned),
    .data  (load_data)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = readData;
    rv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_CLEAR: begin
        cnt_n = cnt + r'(1);
        if (cnt == '1) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (memClear) begin
          state_n = ST_CLEAR;
          cnt_n   = '0;
        end else if (memReq) begin
          if (fault) begin
            err_n = 1'b1;
            if (!memWrite) begin
              rv_n = 1'b1;
              rd_n = '0;
            end
          end else if (!memWrite) begin
            rv_n = 1'b1;
            rd_n = load_data;
          end
        end
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      readData  <= '0;
      readValid <= 1'b0;
      memError  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      readData  <= rd_n;
      readValid <= rv_n;
      memError  <= err_n;
    end
  end

  // Storage array is not reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept && memWrite && !fault) begin
      for (int i = 0; i < int'(nb); i++) begin
        if (lane_mask[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized (n=32, r=7): byte-array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_sized;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memReq = 1'b0, memWrite = 1'b0, memUnsigned = 1'b0, memClear = 1'b0;
  logic [1:0]  memSize = 2'b00;
  logic [31:0] addr = '0, writeData = '0;
  logic [31:0] readData;
  logic        readValid, memError, busy;

  int total = 0;
  int passed = 0;

  dmem_sized #(.n(32), .r(7)) dut (
    .clk(clk), .reset(reset), .memReq(memReq), .memWrite(memWrite),
    .memSize(memSize), .memUnsigned(memUnsigned), .memClear(memClear),
    .addr(addr), .writeData(writeData), .readData(readData),
    .readValid(readValid), .memError(memError), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: flat byte array, clear modelled as a count of remaining busy cycles.
  logic [7:0]  mm [512];
  int          clear_left = 128;
  logic [31:0] m_rd = '0;
  logic        m_rv = 1'b0, m_err = 1'b0;

  initial for (int i = 0; i < 512; i++) mm[i] = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_left = 128;
      m_rd = '0; m_rv = 1'b0; m_err = 1'b0;
      for (int i = 0; i < 512; i++) mm[i] = 8'h00;
    end else begin
      m_rv = 1'b0; m_err = 1'b0;
      if (clear_left > 0) begin
        clear_left--;
      end else if (memClear) begin
        clear_left = 128;
        for (int i = 0; i < 512; i++) mm[i] = 8'h00;
      end else if (memReq) begin
        int bytes;
        logic [63:0] v;
        bytes = 1 << memSize;
        if ((addr % bytes) != 0 || memSize == 2'b11 || addr >= 512) begin
          m_err = 1'b1;
          if (!memWrite) begin m_rv = 1'b1; m_rd = '0; end
        end else if (memWrite) begin
          for (int k = 0; k < bytes; k++) mm[addr + k] = writeData[8*k +: 8];
        end else begin
          v = '0;
          for (int k = 0; k < bytes; k++) v = v | (64'(mm[addr + k]) << (8*k));
          if (!memUnsigned && v[8*bytes-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*bytes));
          m_rd = v[31:0];
          m_rv = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(clear_left > 0));
    chk("readValid", 32'(readValid), 32'(m_rv));
    chk("memError", 32'(memError), 32'(m_err));
    chk("readData", readData, m_rd);
  end

  task automatic tick(input int cnt);
    repeat (cnt) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                       input logic [31:0] d);
    memReq = 1'b1; memWrite = w; memSize = sz; memUnsigned = u; addr = a; writeData = d;
    tick(1);
    memReq = 1'b0; memWrite = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] exp, input bit exp_err);
    issue(1'b0, sz, u, a, '0);
    chk({name, "_rv"}, 32'(readValid), 32'd1);
    chk({name, "_err"}, 32'(memError), 32'(exp_err));
    chk({name, "_rd"}, readData, exp);
  endtask

  task automatic busy_len(input string name, input int exp);
    int c;
    c = 0;
    while (busy && c < 300) begin tick(1); c++; end
    chk(name, 32'(c), 32'(exp));
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    chk("busy_after_reset", 32'(busy), 32'd1);
    busy_len("reset_clear_len", 128);
    load_chk("ld_zero_54", 2'b10, 1'b0, 32'h54, 32'h0000_0000, 1'b0);

    issue(1'b1, 2'b10, 1'b0, 32'h54, 32'hDEAD_BEEF);
    chk("store_no_rv", 32'(readValid), 32'd0);
    load_chk("ld_word_54", 2'b10, 1'b0, 32'h54, 32'hDEAD_BEEF, 1'b0);
    load_chk("ld_sbyte_57", 2'b00, 1'b0, 32'h57, 32'hFFFF_FFDE, 1'b0);
    load_chk("ld_ubyte_57", 2'b00, 1'b1, 32'h57, 32'h0000_00DE, 1'b0);

    issue(1'b1, 2'b10, 1'b0, 32'hA8, 32'h1122_3344);
    issue(1'b1, 2'b01, 1'b0, 32'hAA, 32'h0000_ACAC);
    load_chk("ld_merge_a8", 2'b10, 1'b0, 32'hA8, 32'hACAC_3344, 1'b0);
    load_chk("ld_shalf_aa", 2'b01, 1'b0, 32'hAA, 32'hFFFF_ACAC, 1'b0);

    issue(1'b1, 2'b10, 1'b0, 32'hA9, 32'h5555_5555);
    chk("mis_store_err", 32'(memError), 32'd1);
    chk("mis_store_rv", 32'(readValid), 32'd0);
    load_chk("ld_unchanged_a8", 2'b10, 1'b0, 32'hA8, 32'hACAC_3344, 1'b0);
    load_chk("ld_oor_200", 2'b10, 1'b0, 32'h200, 32'h0, 1'b1);
    load_chk("ld_dword_n32", 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);

    memClear = 1'b1; memReq = 1'b1; memWrite = 1'b0; memSize = 2'b10; addr = 32'h54;
    tick(1);
    memClear = 1'b0; memReq = 1'b0;
    chk("clr_drop_rv", 32'(readValid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    busy_len("memclear_len", 128);
    load_chk("ld_cleared_54", 2'b10, 1'b0, 32'h54, 32'h0, 1'b0);
    load_chk("ld_cleared_a8", 2'b10, 1'b0, 32'hA8, 32'h0, 1'b0);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D);
    memClear = 1'b1; tick(1); memClear = 1'b0;
    tick(49);
    reset = 1'b1; tick(1); reset = 1'b0;
    busy_len("restart_clear_len", 128);
    load_chk("ld_after_restart", 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

    // Randomized traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 4000; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 600);
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      memReq      = ($urandom_range(0, 9) < 7);
      memWrite    = $urandom_range(0, 1) == 1;
      memSize     = ($urandom_range(0, 9) == 0) ? 2'b11 : ((sz == 2'b11) ? 2'b10 : sz);
      memUnsigned = $urandom_range(0, 1) == 1;
      memClear    = ($urandom_range(0, 299) == 0);
      addr        = a;
      writeData   = $urandom;
      reset       = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    memReq = 1'b0; memClear = 1'b0; reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
